wb_udp_csr: RTL and testbench

Wishbone-slave control/status block for the Vthernet receive path. It is the parametrised successor to the fixed MAC/IP/port register set: it adds a configurable table of UDP listen ports with per-entry enables, and byte-lane write strobes. It also adds a received-payload FIFO readable over Wishbone, plus sticky status flags with maskable interrupt. It sits between the PicoRV Wishbone bus and the rx_ethernet/rx_ipv4/rx_udp chain. The UDP payload stream is already synchronised to `wb_clk_i`.

---
 rtl/wb_udp_csr.sv | 187 ++++++++++++++++++
 tb/tb_wb_udp_csr.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_udp_csr.sv
// Wishbone control/status registers for the Vthernet receive path: local MAC/IP,
// UDP listen-port table, received-payload FIFO and sticky status with interrupt.
module wb_udp_csr #(
   parameter int          NUM_PORTS  = 4,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter logic [47:0] MAC_RST    = 48'h01005e0000fb,
   parameter logic [31:0] IP_RST     = 32'he00000fb
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic [47:0]             mac_addr,
   output logic [31:0]             ip_addr,
   output logic [16*NUM_PORTS-1:0] port_tbl,
   output logic [NUM_PORTS-1:0]    port_en,
   input  logic                    rx_data_v,
   input  logic [7:0]              rx_data,
   input  logic                    rx_last,
   output logic                    rx_irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   localparam logic [3:0] W_MAC_LO  = 4'd0;
   localparam logic [3:0] W_MAC_HI  = 4'd1;
   localparam logic [3:0] W_IP      = 4'd2;
   localparam logic [3:0] W_STATUS  = 4'd3;
   localparam logic [3:0] W_IRQ_EN  = 4'd4;
   localparam logic [3:0] W_RX_DATA = 4'd5;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   // Bus decode: one transfer per ack, window of 16 words above BASE_ADDR
   logic [31:0] off;
   logic [3:0]  word;
   logic        in_win, xfer, wr_en, rd_en;

   assign off    = wbs_adr_i - BASE_ADDR;
   assign word   = off[5:2];
   assign in_win = (off[31:6] == 26'd0);
   assign xfer   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
   assign wr_en  = xfer & wbs_we_i & in_win;
   assign rd_en  = xfer & ~wbs_we_i;

   logic [47:0] mac_reg;
   logic [31:0] ip_reg;
   logic [1:0]  irq_en_reg;
   logic        pkt_done_reg, overflow_reg;
   logic [16:0] port_reg [NUM_PORTS];
   logic [16:0] port_rd  [8];

   logic [8:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic [7:0]    level8;
   logic          full, empty, push, pop;
   logic [8:0]    head;

   assign full  = (level_reg == LW'(FIFO_DEPTH));
   assign empty = (level_reg == '0);
   assign head  = fifo_mem[rd_ptr_reg];
   assign push  = rx_data_v & ~full;
   assign pop   = rd_en & in_win & (word == W_RX_DATA) & ~empty;

   always_comb begin
      level8 = '0;
      level8[LW-1:0] = level_reg;
   end

   logic [31:0] mac_lo_next, mac_hi_next, ip_next, irq_en_next;
   logic        st_clr, pkt_done_next, overflow_next;

   assign mac_lo_next = lane_merge(mac_reg[31:0], wbs_dat_i, wbs_sel_i);
   assign mac_hi_next = lane_merge({16'd0, mac_reg[47:32]}, wbs_dat_i, wbs_sel_i);
   assign ip_next     = lane_merge(ip_reg, wbs_dat_i, wbs_sel_i);
   assign irq_en_next = lane_merge({30'd0, irq_en_reg}, wbs_dat_i, wbs_sel_i);

   // Set has priority over a same-edge write-one-to-clear
   assign st_clr        = wr_en & (word == W_STATUS) & wbs_sel_i[0];
   assign pkt_done_next = (push & rx_last) | (pkt_done_reg & ~(st_clr & wbs_dat_i[0]));
   assign overflow_next = (rx_data_v & full) | (overflow_reg & ~(st_clr & wbs_dat_i[1]));

   logic [31:0] rd_data;
   always_comb begin
      rd_data = '0;
      if (in_win) begin
         case (word)
            W_MAC_LO:  rd_data = mac_reg[31:0];
            W_MAC_HI:  rd_data = {16'd0, mac_reg[47:32]};
            W_IP:      rd_data = ip_reg;
            W_STATUS:  rd_data = {16'd0, level8, 4'd0, full, empty, overflow_reg, pkt_done_reg};
            W_IRQ_EN:  rd_data = {30'd0, irq_en_reg};
            W_RX_DATA: rd_data = empty ? 32'd0 : {22'd0, head[8], 1'b1, head[7:0]};
            default:   rd_data = word[3] ? {15'd0, port_rd[word[2:0]]} : 32'd0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= '0;
         mac_reg      <= MAC_RST;
         ip_reg       <= IP_RST;
         irq_en_reg   <= '0;
         pkt_done_reg <= 1'b0;
         overflow_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
      end else begin
         wbs_ack_o    <= xfer;
         if (rd_en)
            wbs_dat_o <= rd_data;
         if (wr_en && word == W_MAC_LO)
            mac_reg[31:0] <= mac_lo_next;
         if (wr_en && word == W_MAC_HI)
            mac_reg[47:32] <= mac_hi_next[15:0];
         if (wr_en && word == W_IP)
            ip_reg <= ip_next;
         if (wr_en && word == W_IRQ_EN)
            irq_en_reg <= irq_en_next[1:0];
         pkt_done_reg <= pkt_done_next;
         overflow_reg <= overflow_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)
            level_reg <= level_reg + LW'(1);
         else if (pop && !push)
            level_reg <= level_reg - LW'(1);
      end
   end

   // Payload storage carries no reset; the pointers define what is valid
   always_ff @(posedge wb_clk_i) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {rx_last, rx_data};
   end

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic [31:0] port_merged;
         assign port_merged = lane_merge({15'd0, port_reg[gi]}, wbs_dat_i, wbs_sel_i);

         always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni)
               port_reg[gi] <= '0;
            else if (wr_en && word == 4'(8 + gi))
               port_reg[gi] <= port_merged[16:0];
         end

         assign port_tbl[16*gi +: 16] = port_reg[gi][15:0];
         assign port_en[gi]           = port_reg[gi][16];
      end

      for (genvar gi = 0; gi < 8; gi++) begin : g_port_rd
         if (gi < NUM_PORTS) begin : g_live
            assign port_rd[gi] = port_reg[gi];
         end else begin : g_absent
            assign port_rd[gi] = '0;
         end
      end
   endgenerate

   assign mac_addr = mac_reg;
   assign ip_addr  = ip_reg;
   assign rx_irq   = |({overflow_reg, pkt_done_reg} & irq_en_reg);

endmodule

// File: tb/tb_wb_udp_csr.sv
// Directed bench for wb_udp_csr: register access, port table, payload FIFO,
// sticky flags and mid-transfer reset.
module tb_wb_udp_csr;

   localparam int          NUM_PORTS  = 4;
   localparam int          FIFO_DEPTH = 16;
   localparam logic [31:0] BASE       = 32'h3000_0000;
   localparam logic [47:0] MAC_RST    = 48'h01005e0000fb;
   localparam logic [31:0] IP_RST     = 32'he00000fb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, dat_i = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic [47:0] mac_addr;
   logic [31:0] ip_addr;
   logic [16*NUM_PORTS-1:0] port_tbl;
   logic [NUM_PORTS-1:0]    port_en;
   logic        rx_v = 1'b0, rx_last = 1'b0;
   logic [7:0]  rx_byte = '0;
   logic        rx_irq;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   wb_udp_csr #(
      .NUM_PORTS(NUM_PORTS), .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE),
      .MAC_RST(MAC_RST), .IP_RST(IP_RST)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .mac_addr(mac_addr), .ip_addr(ip_addr), .port_tbl(port_tbl), .port_en(port_en),
      .rx_data_v(rx_v), .rx_data(rx_byte), .rx_last(rx_last), .rx_irq(rx_irq)
   );

   // Single bus transfer; an ack that never arrives is reported as a failure
   task automatic wb_xfer(input logic w, input logic [31:0] offs, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata);
      int n;
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + offs; dat_i = d; sel = s;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack !== 1'b1 && n < 4);
      tests_run++;
      if (ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL ack_timeout off=%h got ack=%b want 1", offs, ack);
      end
      rdata = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] offs, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] unused;
      wb_xfer(1'b1, offs, d, s, unused);
   endtask

   task automatic wb_read(input logic [31:0] offs, output logic [31:0] rdata);
      wb_xfer(1'b0, offs, 32'd0, 4'hf, rdata);
   endtask

   task automatic push_byte(input logic [7:0] b, input logic l);
      @(posedge clk); #1;
      rx_v = 1'b1; rx_byte = b; rx_last = l;
      @(posedge clk); #1;
      rx_v = 1'b0; rx_last = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      logic        exp_ack;
      tests_run++;
      if (ack !== 1'b0 || dat_o !== 32'd0 || rx_irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs got ack=%b dat=%h irq=%b want 0/0/0", ack, dat_o, rx_irq);
      end
      tests_run++;
      if (mac_addr !== MAC_RST || ip_addr !== IP_RST || port_en !== '0 || port_tbl !== '0) begin
         tests_failed++;
         $display("FAIL reset_regs got mac=%h ip=%h en=%b want %h %h 0", mac_addr, ip_addr, port_en, MAC_RST, IP_RST);
      end
      wb_read(32'h00, r);
      tests_run++;
      if (r !== 32'h5e0000fb) begin tests_failed++; $display("FAIL read_mac_low got %h want 5e0000fb", r); end
      wb_read(32'h04, r);
      tests_run++;
      if (r !== 32'h00000100) begin tests_failed++; $display("FAIL read_mac_high got %h want 00000100", r); end
      wb_read(32'h08, r);
      tests_run++;
      if (r !== 32'he00000fb) begin tests_failed++; $display("FAIL read_ip got %h want e00000fb", r); end
      wb_read(32'h18, r);
      tests_run++;
      if (r !== 32'd0) begin tests_failed++; $display("FAIL read_unmapped got %h want 0", r); end
      // Held strobe: ack alternates 1,0,1,0
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         exp_ack = (i % 2 == 0);
         tests_run++;
         if (ack !== exp_ack) begin
            tests_failed++;
            $display("FAIL ack_pulse cycle=%0d got %b want %b", i, ack, exp_ack);
         end
      end
      stb = 1'b0; cyc = 1'b0;
      tests_run++;
      if (dat_o !== 32'h5e0000fb) begin tests_failed++; $display("FAIL held_read_data got %h want 5e0000fb", dat_o); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_port;
      logic [31:0] r;
      wb_write(32'h24, 32'h0001_ffff, 4'hf);
      wb_write(32'h24, 32'h0000_1234, 4'b0001);
      wb_read(32'h24, r);
      tests_run++;
      if (r !== 32'h0001_ff34) begin tests_failed++; $display("FAIL port1_readback got %h want 0001ff34", r); end
      tests_run++;
      if (port_tbl[31:16] !== 16'hff34 || port_en !== 4'b0010) begin
         tests_failed++;
         $display("FAIL port1_outputs got tbl=%h en=%b want ff34 0010", port_tbl[31:16], port_en);
      end
      wb_write(32'h04, 32'hffff_abcd, 4'b0010);
      wb_read(32'h04, r);
      tests_run++;
      if (r !== 32'h0000_ab00 || mac_addr !== 48'hab005e0000fb) begin
         tests_failed++;
         $display("FAIL mac_high_lane got %h mac=%h want 0000ab00 ab005e0000fb", r, mac_addr);
      end
      $display("[TB] test_port done");
   endtask

   task automatic test_fifo_basic;
      logic [31:0] r;
      logic [31:0] exp_rd [3];
      exp_rd[0] = 32'h111; exp_rd[1] = 32'h322; exp_rd[2] = 32'h000;
      wb_write(32'h10, 32'h1, 4'hf);
      push_byte(8'h11, 1'b0);
      tests_run++;
      if (rx_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_early got %b want 0", rx_irq); end
      push_byte(8'h22, 1'b1);
      tests_run++;
      if (rx_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_after_last got %b want 1", rx_irq); end
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0201) begin tests_failed++; $display("FAIL status_two got %h want 00000201", r); end
      for (int i = 0; i < 3; i++) begin
         wb_read(32'h14, r);
         tests_run++;
         if (r !== exp_rd[i]) begin tests_failed++; $display("FAIL rx_pop%0d got %h want %h", i, r, exp_rd[i]); end
      end
      wb_write(32'h0c, 32'h1, 4'h1);
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0004 || rx_irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL status_cleared got %h irq=%b want 00000004 0", r, rx_irq);
      end
      $display("[TB] test_fifo_basic done");
   endtask

   task automatic test_overflow;
      logic [31:0] r;
      for (int i = 0; i < FIFO_DEPTH + 3; i++)
         push_byte(8'(8'h40 + i), 1'b0);
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h100a) begin tests_failed++; $display("FAIL status_full got %h want 0000100a", r); end
      tests_run++;
      if (rx_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_masked_ovf got %b want 0", rx_irq); end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         wb_read(32'h14, r);
         tests_run++;
         if (r !== 32'h100 + 32'(8'h40 + i)) begin
            tests_failed++;
            $display("FAIL ovf_pop%0d got %h want %h", i, r, 32'h100 + 32'(8'h40 + i));
         end
      end
      push_byte(8'h99, 1'b1);
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0103) begin tests_failed++; $display("FAIL status_both got %h want 00000103", r); end
      wb_write(32'h0c, 32'h2, 4'h1);
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0101) begin tests_failed++; $display("FAIL clear_ovf_only got %h want 00000101", r); end
      wb_read(32'h14, r);
      tests_run++;
      if (r !== 32'h399) begin tests_failed++; $display("FAIL last_pop got %h want 00000399", r); end
      wb_write(32'h0c, 32'h1, 4'h1);
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0004) begin tests_failed++; $display("FAIL status_idle got %h want 00000004", r); end
      $display("[TB] test_overflow done");
   endtask

   task automatic test_same_cycle;
      logic [31:0] r;
      for (int i = 0; i < 5; i++)
         push_byte(8'(8'h50 + i), 1'b0);
      // Pop and push on the same edge
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h14; sel = 4'hf;
      rx_v = 1'b1; rx_byte = 8'h55; rx_last = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; rx_v = 1'b0; rx_last = 1'b0;
      tests_run++;
      if (ack !== 1'b1 || dat_o !== 32'h150) begin
         tests_failed++;
         $display("FAIL pop_with_push got ack=%b dat=%h want 1 00000150", ack, dat_o);
      end
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0501) begin tests_failed++; $display("FAIL level_kept got %h want 00000501", r); end
      // W1C of pkt_done on the same edge as a last-byte push
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h0c; dat_i = 32'h1; sel = 4'h1;
      rx_v = 1'b1; rx_byte = 8'h56; rx_last = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0; rx_v = 1'b0; rx_last = 1'b0;
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0601) begin tests_failed++; $display("FAIL set_beats_clear got %h want 00000601", r); end
      wb_read(32'h14, r);
      tests_run++;
      if (r !== 32'h151) begin tests_failed++; $display("FAIL pop_51 got %h want 00000151", r); end
      wb_read(32'h14, r);
      tests_run++;
      if (r !== 32'h152) begin tests_failed++; $display("FAIL pop_52 got %h want 00000152", r); end
      $display("[TB] test_same_cycle done");
   endtask

   task automatic test_reset_mid;
      logic [31:0] r;
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0401 || rx_irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_status got %h irq=%b want 00000401 1", r, rx_irq);
      end
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE; sel = 4'hf;
      @(posedge clk); #1;
      tests_run++;
      if (ack !== 1'b1) begin tests_failed++; $display("FAIL mid_ack_high got %b want 1", ack); end
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if (ack !== 1'b0 || rx_irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL ack_drop got ack=%b irq=%b want 0 0", ack, rx_irq);
      end
      we = 1'b1; adr = BASE + 32'h08; dat_i = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (ack !== 1'b0 || ip_addr !== IP_RST) begin
         tests_failed++;
         $display("FAIL write_in_reset got ack=%b ip=%h want 0 %h", ack, ip_addr, IP_RST);
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wb_read(32'h0c, r);
      tests_run++;
      if (r !== 32'h0004) begin tests_failed++; $display("FAIL post_reset_status got %h want 00000004", r); end
      wb_read(32'h10, r);
      tests_run++;
      if (r !== 32'h0) begin tests_failed++; $display("FAIL post_reset_irq_en got %h want 0", r); end
      tests_run++;
      if (mac_addr !== MAC_RST || port_en !== '0) begin
         tests_failed++;
         $display("FAIL post_reset_regs got mac=%h en=%b want %h 0", mac_addr, port_en, MAC_RST);
      end
      wb_write(32'h08, 32'hc0a8_0001, 4'hf);
      wb_read(32'h08, r);
      tests_run++;
      if (r !== 32'hc0a8_0001 || ip_addr !== 32'hc0a8_0001) begin
         tests_failed++;
         $display("FAIL post_reset_write got %h ip=%h want c0a80001", r, ip_addr);
      end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_port();
      test_fifo_basic();
      test_overflow();
      test_same_cycle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
